// File: rtl/asc_sched_pkg.sv
// asc_sched_pkg: shared types and widths for the multi-channel AXI command scheduler
// Holds the exec FSM state encoding and the queued command record.
// cmd_t widths follow the PKG_* localparams; the top-level parameters default to them and must match.
package asc_sched_pkg;
  localparam int PKG_PACKET_SIZE = 256;
  localparam int PKG_ADDR_WIDTH = 32;
  localparam int PKG_NUM_CH = 4;
  localparam int TAG_W = $clog2(PKG_NUM_CH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic wen;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_PACKET_SIZE-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/asc_axi_cmd_sched_fifo.sv
// asc_cmd_fifo: DEPTH-entry synchronous FIFO of cmd_t with occupancy count
// Ports: clk/rst (async active-high), push_i/din_i write side, pop_i/dout_o read side
// (dout_o shows the head combinationally), count_o occupancy 0..DEPTH.
// The scheduler never pushes when full nor pops when empty.
module asc_cmd_fifo import asc_sched_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  cmd_t                   din_i,
  input  logic                   pop_i,
  output cmd_t                   dout_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/asc_axi_cmd_sched.sv
// asc_axi_cmd_sched: round-robin multi-channel command scheduler onto a single AXI start/done master
// Ports: ACLK/rst (async active-high); ch_req_* per-channel requests with one-hot combinational ready;
// ch_rsp_* one-hot completion pulse with read data and timeout flag; synced_wr_*/synced_rd_* start
// pulses with address/data to the AXI master and axi_*_done completions; q_count queue occupancy; busy.
module asc_axi_cmd_sched import asc_sched_pkg::*; #(
  parameter int PACKET_SIZE = PKG_PACKET_SIZE,
  parameter int ADDR_WIDTH  = PKG_ADDR_WIDTH,
  parameter int NUM_CH      = PKG_NUM_CH,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                          ACLK,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  output logic [NUM_CH-1:0]             ch_req_ready,
  input  logic [NUM_CH-1:0]             ch_req_wen,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]  ch_req_addr,
  input  logic [NUM_CH*PACKET_SIZE-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]             ch_rsp_valid,
  output logic [PACKET_SIZE-1:0]        ch_rsp_rdata,
  output logic                          ch_rsp_err,
  output logic                          synced_wr_start,
  output logic [ADDR_WIDTH-1:0]         synced_wr_addr,
  output logic [PACKET_SIZE-1:0]        synced_wr_data,
  input  logic                          axi_wr_done,
  output logic                          synced_rd_start,
  output logic [ADDR_WIDTH-1:0]         synced_rd_addr,
  input  logic                          axi_rd_done,
  input  logic [PACKET_SIZE-1:0]        axi_rd_data,
  output logic [$clog2(DEPTH):0]        q_count,
  output logic                          busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d, elig;
  logic [TAG_W-1:0] rr_q, rr_d, gidx;
  logic found, full, accept, act, done, rd_done_m, tmo, err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0] rdata_q, rdata_d;
  cmd_t push_cmd, head;
  assign elig = ch_req_valid & ~pend_q;
  // rr_q holds the channel searched first, i.e. the one after the last grant
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!found && elig[(int'(rr_q) + i) % NUM_CH]) begin
        found = 1'b1;
        gidx = TAG_W'((int'(rr_q) + i) % NUM_CH);
      end
  end
  // fullness is judged on the registered count, so a same-cycle pop never frees a slot early
  assign full = q_count == CW'(DEPTH);
  assign accept = found && !full;
  assign ch_req_ready = accept ? NUM_CH'(1) << gidx : '0;
  assign push_cmd = '{tag: gidx, wen: ch_req_wen[gidx],
                      addr: ch_req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH],
                      wdata: ch_req_wdata[gidx*PACKET_SIZE +: PACKET_SIZE]};
  assign rr_d = accept ? (gidx == TAG_W'(NUM_CH - 1) ? '0 : gidx + 1'b1) : rr_q;
  assign pend_d = (pend_q & ~ch_rsp_valid) | ch_req_ready;
  asc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(ACLK), .rst(rst), .push_i(accept), .din_i(push_cmd),
    .pop_i(state_q == RESP), .dout_o(head), .count_o(q_count)
  );
  assign rd_done_m = !head.wen && axi_rd_done;
  assign done = rd_done_m || (head.wen && axi_wr_done);
  // cnt_q is 0 in ISSUE, so the TIMEOUT-th cycle after ISSUE is RESP
  assign tmo = TIMEOUT != 0 && cnt_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        rdata_d = '0;
        if (q_count != '0) state_d = ISSUE;
      end
      ISSUE, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        state_d = WAIT;
        if (done || tmo) begin
          state_d = RESP;
          err_d = !done;
          rdata_d = rd_done_m ? axi_rd_data : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  assign act = state_q != IDLE;
  assign synced_wr_start = state_q == ISSUE && head.wen;
  assign synced_rd_start = state_q == ISSUE && !head.wen;
  assign synced_wr_addr = act ? head.addr : '0;
  assign synced_rd_addr = act ? head.addr : '0;
  assign synced_wr_data = act ? head.wdata : '0;
  assign ch_rsp_valid = state_q == RESP ? NUM_CH'(1) << head.tag : '0;
  assign ch_rsp_err = state_q == RESP && err_q;
  assign ch_rsp_rdata = state_q == RESP ? rdata_q : '0;
  assign busy = act || q_count != '0;
endmodule

// File: tb/tb_asc_axi_cmd_sched.sv
// tb_asc_axi_cmd_sched: directed table-driven bench for the command scheduler
module tb_asc_axi_cmd_sched;
  localparam logic [255:0] WD0 = {32'hDEADBEEF, 192'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978, 32'h9ABCDEF0};
  typedef struct {
    int ch;
    logic wen;
    logic [31:0] addr;
    logic [255:0] wdata;
    logic [255:0] rd_in;
    int dly;
    logic noise;
    logic [3:0] exp_rsp;
    logic exp_err;
    logic [255:0] exp_rdata;
  } vec_t;
  logic ACLK = 0, rst = 1;
  logic [3:0] valid = '0, valid_b = '0, wen = '0;
  logic [127:0] addr = '0;
  logic [1023:0] wdata = '0;
  logic wr_done = 0, rd_done = 0;
  logic [255:0] rd_data = '0;
  logic [3:0] ready, rsp_v, ready_b, rsp_v_b;
  logic [255:0] rdata, wr_data, rdata_b, wr_data_b;
  logic err, wr_start, rd_start, busy, err_b, wr_start_b, rd_start_b, busy_b;
  logic [31:0] wr_addr, rd_addr, wr_addr_b, rd_addr_b;
  logic [2:0] q_count;
  logic [1:0] q_count_b;
  int total = 0, bad = 0;
  vec_t tbl [6];

  always #5 ACLK = ~ACLK;

  asc_axi_cmd_sched #(.DEPTH(4), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .rst(rst), .ch_req_valid(valid), .ch_req_ready(ready), .ch_req_wen(wen),
    .ch_req_addr(addr), .ch_req_wdata(wdata), .ch_rsp_valid(rsp_v), .ch_rsp_rdata(rdata),
    .ch_rsp_err(err), .synced_wr_start(wr_start), .synced_wr_addr(wr_addr), .synced_wr_data(wr_data),
    .axi_wr_done(wr_done), .synced_rd_start(rd_start), .synced_rd_addr(rd_addr),
    .axi_rd_done(rd_done), .axi_rd_data(rd_data), .q_count(q_count), .busy(busy)
  );

  asc_axi_cmd_sched #(.DEPTH(2), .TIMEOUT(16)) dut_b (
    .ACLK(ACLK), .rst(rst), .ch_req_valid(valid_b), .ch_req_ready(ready_b), .ch_req_wen(wen),
    .ch_req_addr(addr), .ch_req_wdata(wdata), .ch_rsp_valid(rsp_v_b), .ch_rsp_rdata(rdata_b),
    .ch_rsp_err(err_b), .synced_wr_start(wr_start_b), .synced_wr_addr(wr_addr_b), .synced_wr_data(wr_data_b),
    .axi_wr_done(1'b0), .synced_rd_start(rd_start_b), .synced_rd_addr(rd_addr_b),
    .axi_rd_done(1'b0), .axi_rd_data(rd_data), .q_count(q_count_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    n = v.dly < 0 ? 15 : v.dly;
    valid = '0;
    valid[v.ch] = 1'b1;
    wen[v.ch] = v.wen;
    addr[v.ch*32 +: 32] = v.addr;
    wdata[v.ch*256 +: 256] = v.wdata;
    rd_data = v.rd_in;
    #1 chk("ready", ready, 4'(1) << v.ch);
    @(posedge ACLK); #1;
    valid = '0;
    #1 chk("q_count_acc", q_count, 1);
    @(posedge ACLK); #1;
    chk("start", {wr_start, rd_start}, v.wen ? 2'b10 : 2'b01);
    chk("start_addr", v.wen ? wr_addr : rd_addr, v.addr);
    if (v.wen) chk("start_wdata", wr_data, v.wdata);
    for (int i = 0; i <= n; i++) begin
      chk("early_rsp", rsp_v, 0);
      if (i > 0) chk("start_once", {wr_start, rd_start}, 0);
      if (i == 0 && v.noise && n > 0) begin
        if (v.wen) rd_done = 1'b1; else wr_done = 1'b1;
      end
      if (i == n && v.dly >= 0) begin
        if (v.wen) wr_done = 1'b1; else rd_done = 1'b1;
      end
      @(posedge ACLK); #1;
      wr_done = 1'b0;
      rd_done = 1'b0;
    end
    chk("rsp_valid", rsp_v, v.exp_rsp);
    chk("rsp_err", err, v.exp_err);
    chk("rsp_rdata", rdata, v.exp_rdata);
    chk("held_addr", v.wen ? wr_addr : rd_addr, v.addr);
    @(posedge ACLK); #1;
    chk("idle_rsp", rsp_v, 0);
    chk("idle_busy", {busy, q_count}, 0);
    chk("idle_addr", {wr_addr, rd_addr}, 0);
  endtask

  initial begin
    int acc_cyc [4], acc_ch [4], st_cyc [4], st_ch [4], rs_ch [4];
    int na, ns, nr, errs;
    logic [3:0] acc_prev;
    logic dn;
    tbl[0] = '{0, 1'b1, 32'hC000_0000, WD0, 256'h0, 3, 1'b0, 4'b0001, 1'b0, 256'h0};
    tbl[1] = '{2, 1'b0, 32'hC000_0000, 256'h0, 256'h876543210FEDCBA9, 2, 1'b1, 4'b0100, 1'b0, 256'h876543210FEDCBA9};
    tbl[2] = '{3, 1'b1, 32'h1000_0040, ~WD0, 256'h0, 0, 1'b0, 4'b1000, 1'b0, 256'h0};
    tbl[3] = '{1, 1'b0, 32'h2000_0100, 256'h0, 256'h5555_AAAA, -1, 1'b1, 4'b0010, 1'b1, 256'h0};
    tbl[4] = '{2, 1'b1, 32'h3000_0200, WD0 ^ 256'hFF, 256'h1234, -1, 1'b1, 4'b0100, 1'b1, 256'h0};
    tbl[5] = '{0, 1'b0, 32'h4000_0300, 256'h0, 256'hCAFE_F00D, 15, 1'b0, 4'b0001, 1'b0, 256'hCAFE_F00D};
    #1;
    chk("rst_outs", {wr_start, rd_start, rsp_v, err, busy, q_count}, 0);
    chk("rst_addr", {wr_addr, rd_addr}, 0);
    repeat (2) @(posedge ACLK);
    #1 rst = 0;
    @(posedge ACLK); #1;
    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    valid = 4'b0010;
    wen[1] = 1'b1;
    addr[32 +: 32] = 32'h2000_0000;
    wdata[256 +: 256] = WD0;
    @(posedge ACLK); #1;
    valid = '0;
    @(posedge ACLK); #1;
    chk("mid_start", wr_start, 1);
    repeat (2) @(posedge ACLK);
    #3 rst = 1;
    #1;
    chk("mid_rst_outs", {wr_start, rd_start, rsp_v, err, busy, q_count}, 0);
    chk("mid_rst_addr", {wr_addr, rd_addr}, 0);
    chk("mid_rst_wdata", wr_data, 0);
    chk("mid_rst_rdata", rdata, 0);
    @(posedge ACLK); #1;
    rst = 0;
    @(posedge ACLK); #1;
    wr_done = 1'b1;
    @(posedge ACLK); #1;
    wr_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_done", {rsp_v, busy, wr_start}, 0);
      @(posedge ACLK); #1;
    end

    for (int c = 0; c < 4; c++) begin
      acc_cyc[c] = -1; acc_ch[c] = -1; st_cyc[c] = -1; st_ch[c] = -1; rs_ch[c] = -1;
      addr[c*32 +: 32] = 32'hA000_0000 + 32'(c * 16);
    end
    na = 0; ns = 0; nr = 0; errs = 0;
    acc_prev = '0;
    dn = 1'b0;
    wen = 4'b1111;
    valid = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      valid = valid & ~acc_prev;
      wr_done = dn;
      #1;
      if (ready != 0 && na < 4) begin acc_cyc[na] = k; acc_ch[na] = oh2i(ready); na++; end
      if (wr_start && ns < 4) begin st_cyc[ns] = k; st_ch[ns] = int'(wr_addr[5:4]); ns++; end
      if (rsp_v != 0 && nr < 4) begin rs_ch[nr] = oh2i(rsp_v); if (err) errs++; nr++; end
      acc_prev = ready;
      dn = wr_start;
      @(posedge ACLK); #1;
    end
    wr_done = 1'b0;
    valid = '0;
    for (int c = 0; c < 4; c++) begin
      chk("rr_acc_ch", acc_ch[c], c);
      chk("rr_acc_cyc", acc_cyc[c], acc_cyc[0] + c);
      chk("rr_start_ch", st_ch[c], c);
      chk("rr_rsp_ch", rs_ch[c], c);
    end
    chk("rr_latency", st_cyc[0], acc_cyc[0] + 2);
    chk("rr_errs", errs, 0);

    wen = '0;
    valid_b = 4'b1111;
    #1 chk("b_ready0", ready_b, 4'b0001);
    @(posedge ACLK); #1;
    valid_b = 4'b0001;
    #1 chk("b_pend_mask", ready_b, 0);
    chk("b_qc1", q_count_b, 1);
    @(posedge ACLK); #1;
    valid_b = 4'b1111;
    #1 chk("b_ready1", ready_b, 4'b0010);
    @(posedge ACLK); #1;
    valid_b = 4'b1101;
    #1 chk("b_full_qc", q_count_b, 2);
    for (int c = 3; c < 18; c++) begin
      chk("b_full_ready", ready_b, 0);
      chk("b_no_rsp", rsp_v_b, 0);
      @(posedge ACLK); #1;
    end
    chk("b_tmo_rsp", rsp_v_b, 4'b0001);
    chk("b_tmo_err", err_b, 1);
    chk("b_tmo_rdata", rdata_b, 0);
    chk("b_tmo_ready", ready_b, 0);
    @(posedge ACLK); #1;
    chk("b_next_acc", ready_b, 4'b0100);
    @(posedge ACLK); #1;
    valid_b = '0;
    chk("b_next_start", rd_start_b, 1);
    chk("b_next_addr", rd_addr_b, 32'hA000_0010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
